// File: rtl/bram_axil_pkg.sv
// Shared constants, types and width helpers for the AXI4-Lite block-RAM slave.
package bram_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      RdIdle,
      RdPipe,
      RdResp
   } rd_state_e;

   // Number of address bits that select a byte within one data word.
   function automatic int unsigned byte_off_w(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int unsigned strb_w(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/bram_sdp_bytewe.sv
// Simple-dual-port RAM: byte-enabled write port, registered read-first read port.
// Defining BRAM_OUTREG_EN adds one more output register stage on the read data.
module bram_sdp_bytewe
   import bram_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 4096,
   parameter int unsigned RAM_AW     = 12
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [RAM_AW-1:0]       waddr,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    re,
   input  logic [RAM_AW-1:0]       raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned StrbW = strb_w(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_q, rd_d;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < StrbW; i++) begin
            if (wstrb[i]) begin
               mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Non-blocking update of mem_q makes a same-edge read return the old word.
   always_comb begin
      rd_d = rd_q;
      if (re) begin
         rd_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      rd_q <= rd_d;
   end

`ifdef BRAM_OUTREG_EN
   logic [DATA_WIDTH-1:0] out_q, out_d;

   always_comb begin
      out_d = rd_q;
   end

   always_ff @(posedge clk) begin
      out_q <= out_d;
   end

   assign rdata = out_q;
`else
   assign rdata = rd_q;
`endif

endmodule

// File: rtl/bram_axil_slave.sv
// AXI4-Lite slave fronting a byte-enabled SDP block RAM with SLVERR on out-of-range words.
// Defining BRAM_OUTREG_EN pipelines the read data one extra cycle (read latency 2).
module bram_axil_slave
   import bram_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned MEM_DEPTH  = 4096
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int unsigned OffW   = byte_off_w(DATA_WIDTH);
   localparam int unsigned StrbW  = strb_w(DATA_WIDTH);
   localparam int unsigned IdxW   = ADDR_WIDTH - OffW;
   localparam int unsigned RamAw  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [IdxW:0] DepthLim = (IdxW + 1)'(MEM_DEPTH);

`ifdef BRAM_OUTREG_EN
   localparam rd_state_e RdAfterAr = RdPipe;
`else
   localparam rd_state_e RdAfterAr = RdResp;
`endif

   // Readies stay low until the first edge after reset release.
   logic init_q, init_d;

   logic             aw_full_q, aw_full_d;
   logic [IdxW-1:0]  aw_idx_q, aw_idx_d;
   logic             w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [StrbW-1:0] w_strb_q, w_strb_d;
   logic             bvalid_q, bvalid_d;
   logic [1:0]       bresp_q, bresp_d;

   rd_state_e        rd_state_q, rd_state_d;
   logic             rd_oor_q, rd_oor_d;
   logic             resp_oor;

   logic             aw_hs, w_hs, ar_hs, wr_commit, aw_oor, ar_oor;
   logic [IdxW-1:0]  ar_idx;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Byte-offset bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{awaddr, araddr};

   // ---------------- write path ----------------
   always_comb begin
      init_d    = 1'b1;
      aw_oor    = ({1'b0, aw_idx_q} >= DepthLim);
      wr_commit = aw_full_q && w_full_q && (!bvalid_q || bready);
      // A committing entry frees its slot on the same edge, so refills keep one commit per cycle.
      awready   = init_q && (!aw_full_q || wr_commit);
      wready    = init_q && (!w_full_q || wr_commit);
      aw_hs     = awvalid && awready;
      w_hs      = wvalid && wready;

      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = awaddr[ADDR_WIDTH-1:OffW];
      end else if (wr_commit) begin
         aw_full_d = 1'b0;
      end

      w_full_d = w_full_q;
      w_data_d = w_data_q;
      w_strb_d = w_strb_q;
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = wdata;
         w_strb_d = wstrb;
      end else if (wr_commit) begin
         w_full_d = 1'b0;
      end

      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (wr_commit) begin
         bvalid_d = 1'b1;
         bresp_d  = aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (bready) begin
         bvalid_d = 1'b0;
      end

      bvalid = bvalid_q;
      bresp  = bresp_q;
   end

   // ---------------- read path ----------------
   always_comb begin
      ar_idx   = araddr[ADDR_WIDTH-1:OffW];
      ar_oor   = ({1'b0, ar_idx} >= DepthLim);
      ar_hs    = arvalid && arready;
      rd_oor_d = ar_hs ? ar_oor : rd_oor_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_state_q <= RdIdle;
      end else begin
         rd_state_q <= rd_state_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RdIdle:  if (ar_hs) rd_state_d = RdAfterAr;
         RdPipe:  rd_state_d = RdResp;
         RdResp:  if (rready) rd_state_d = RdIdle;
         default: rd_state_d = RdIdle;
      endcase
   end

   always_comb begin
      arready = init_q && (rd_state_q == RdIdle);
      rvalid  = (rd_state_q == RdResp);
      rresp   = (rvalid && resp_oor) ? RESP_SLVERR : RESP_OKAY;
      rdata   = (rvalid && !resp_oor) ? ram_rdata : '0;
   end

`ifdef BRAM_OUTREG_EN
   logic rd_oor2_q, rd_oor2_d;

   always_comb begin
      rd_oor2_d = rd_oor_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_oor2_q <= 1'b0;
      end else begin
         rd_oor2_q <= rd_oor2_d;
      end
   end

   assign resp_oor = rd_oor2_q;
`else
   assign resp_oor = rd_oor_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         init_q    <= 1'b0;
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rd_oor_q  <= 1'b0;
      end else begin
         init_q    <= init_d;
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rd_oor_q  <= rd_oor_d;
      end
   end

   bram_sdp_bytewe #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .RAM_AW     (RamAw)
   ) u_ram (
      .clk   (clk),
      .we    (wr_commit && !aw_oor),
      .waddr (aw_idx_q[RamAw-1:0]),
      .wstrb (w_strb_q),
      .wdata (w_data_q),
      .re    (ar_hs && !ar_oor),
      .raddr (ar_idx[RamAw-1:0]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_bram_axil_slave.sv
// Directed self-checking bench for bram_axil_slave (MEM_DEPTH = 3000, 32-bit data).
module tb_bram_axil_slave;

   localparam int DW    = 32;
   localparam int AW    = 14;
   localparam int DEPTH = 3000;
`ifdef BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] got_d;
   logic [1:0]    got_r;

   always #5 clk = ~clk;

   bram_axil_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [AW-1:0] a);
      logic done = 1'b0;
      awaddr  = a;
      awvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (awready) begin
            tick();
            done = 1'b1;
         end
      end
      awvalid = 1'b0;
      check_eq("aw_handshake", {63'd0, done}, 64'd1);
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
      logic done = 1'b0;
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (wready) begin
            tick();
            done = 1'b1;
         end
      end
      wvalid = 1'b0;
      check_eq("w_handshake", {63'd0, done}, 64'd1);
   endtask

   task automatic wait_b(output logic [1:0] resp);
      logic done = 1'b0;
      resp   = 2'bxx;
      bready = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (bvalid) begin
            resp = bresp;
            tick();
            done = 1'b1;
         end
      end
      bready = 1'b0;
      check_eq("b_handshake", {63'd0, done}, 64'd1);
   endtask

   task automatic issue_ar(input logic [AW-1:0] a);
      logic done = 1'b0;
      araddr  = a;
      arvalid = 1'b1;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (arready) begin
            tick();
            done = 1'b1;
         end
      end
      arvalid = 1'b0;
      check_eq("ar_handshake", {63'd0, done}, 64'd1);
   endtask

   // Entered #1 after the AR handshake edge; measures latency then takes the beat.
   task automatic collect_r(input string tag, output logic [DW-1:0] d, output logic [1:0] r);
      int lat = 1;
      while (!rvalid && lat < 8) begin
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, lat, LAT);
      d      = rdata;
      r      = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic read_word(input string tag, input logic [AW-1:0] a,
                            output logic [DW-1:0] d, output logic [1:0] r);
      issue_ar(a);
      collect_r(tag, d, r);
   endtask

   initial begin
      reset_n = 1'b0;
      {awaddr, awvalid, wdata, wstrb, wvalid, bready} = '0;
      {araddr, arvalid, rready} = '0;

      // Reset state
      repeat (3) tick();
      check_eq("rst_ready", {awready, wready, arready}, 3'b000);
      check_eq("rst_valid", {bvalid, rvalid}, 2'b00);
      check_eq("rst_resp", {bresp, rresp}, 4'b0000);
      check_eq("rst_rdata", rdata, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_eq("ready_before_edge", {awready, wready, arready}, 3'b000);
      tick();
      check_eq("ready_after_rel", {awready, wready, arready}, 3'b111);

      // AW first, W three cycles later
      send_aw(14'h010);
      check_eq("aw_full_awready", {awready, wready}, 2'b01);
      tick();
      tick();
      send_w(32'hDEADBEEF, 4'hF);
      wait_b(got_r);
      check_eq("wr1_bresp", got_r, 2'b00);
      read_word("rd1", 14'h010, got_d, got_r);
      check_eq("rd1_data", got_d, 32'hDEADBEEF);
      check_eq("rd1_rresp", got_r, 2'b00);

      // W before AW with partial strobes
      send_w(32'h11223344, 4'h5);
      check_eq("w_full_wready", {awready, wready}, 2'b10);
      send_aw(14'h010);
      wait_b(got_r);
      check_eq("wr2_bresp", got_r, 2'b00);
      read_word("rd2", 14'h010, got_d, got_r);
      check_eq("rd2_data", got_d, 32'hDE22BE44);

      // Last in-range word, then first out-of-range word
      send_aw(14'd11996);
      send_w(32'h0BADF00D, 4'hF);
      wait_b(got_r);
      check_eq("last_bresp", got_r, 2'b00);
      send_aw(14'd12000);
      send_w(32'hFFFFFFFF, 4'hF);
      wait_b(got_r);
      check_eq("oor_bresp", got_r, 2'b10);
      read_word("oor_rd", 14'd12000, got_d, got_r);
      check_eq("oor_rresp", got_r, 2'b10);
      check_eq("oor_rdata", got_d, 0);
      read_word("last_rd", 14'd11996, got_d, got_r);
      check_eq("last_rdata", got_d, 32'h0BADF00D);
      check_eq("last_rresp", got_r, 2'b00);
      read_word("rd_after_oor", 14'h010, got_d, got_r);
      check_eq("mem_unchanged", got_d, 32'hDE22BE44);

      // Backpressure: second pair parks in the holding registers
      send_aw(14'h020);
      send_w(32'h00000001, 4'hF);
      send_aw(14'h024);
      send_w(32'h00000002, 4'hF);
      repeat (5) tick();
      check_eq("bp_readies", {awready, wready}, 2'b00);
      check_eq("bp_bvalid", bvalid, 1'b1);
      bready = 1'b1;
      tick();
      check_eq("bp_second_b", {bvalid, bresp}, 3'b100);
      tick();
      check_eq("bp_drained", {bvalid, awready, wready}, 3'b011);
      bready = 1'b0;
      read_word("bp_rd0", 14'h020, got_d, got_r);
      check_eq("bp_data0", got_d, 32'h00000001);
      read_word("bp_rd1", 14'h024, got_d, got_r);
      check_eq("bp_data1", got_d, 32'h00000002);

      // Read-first on a same-edge commit; pending B is a wstrb=0 no-op
      send_aw(14'h030);
      send_w(32'h55555555, 4'hF);
      wait_b(got_r);
      send_aw(14'h010);
      send_w(32'hFFFFFFFF, 4'h0);
      tick();
      send_aw(14'h030);
      send_w(32'hAAAAAAAA, 4'hF);
      araddr  = 14'h030;
      arvalid = 1'b1;
      bready  = 1'b1;
      @(negedge clk);
      check_eq("rf_arready", arready, 1'b1);
      check_eq("strb0_b", {bvalid, bresp}, 3'b100);
      tick();
      arvalid = 1'b0;
      bready  = 1'b0;
      collect_r("rf", got_d, got_r);
      check_eq("rf_old_data", got_d, 32'h55555555);
      wait_b(got_r);
      check_eq("rf_bresp", got_r, 2'b00);
      read_word("rf_new", 14'h030, got_d, got_r);
      check_eq("rf_new_data", got_d, 32'hAAAAAAAA);
      read_word("strb0_rd", 14'h010, got_d, got_r);
      check_eq("strb0_data", got_d, 32'hDE22BE44);

      // Reset with R beat, B response and AW entry all pending
      send_aw(14'h044);
      send_w(32'h00000099, 4'hF);
      tick();
      send_aw(14'h040);
      issue_ar(14'h010);
      repeat (LAT - 1) tick();
      check_eq("pre_rst_state", {rvalid, bvalid, awready}, 3'b110);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", {rvalid, bvalid}, 2'b00);
      check_eq("mid_rst_rdata", rdata, 0);
      check_eq("mid_rst_ready", {awready, wready, arready}, 3'b000);
      repeat (2) tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check_eq("post_rst_ready", {awready, wready, arready}, 3'b111);
      repeat (3) tick();
      check_eq("post_rst_nob", {bvalid, rvalid}, 2'b00);
      read_word("post_rst_rd", 14'h010, got_d, got_r);
      check_eq("post_rst_data", got_d, 32'hDE22BE44);
      read_word("post_rst_rd2", 14'h044, got_d, got_r);
      check_eq("post_rst_data2", got_d, 32'h00000099);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
